// File: rtl/xadc_drp_responder.sv
// xadc_drp_responder: DRP responder and free-running channel sequencer standing in for the XADC macro
module xadc_drp_responder #(
    parameter int CONV_CYCLES = 26,
    parameter int DRP_LAT     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [6:0]  daddr_in,
    input  logic [15:0] di_in,
    output logic        drdy_out,
    output logic [15:0] do_out,
    output logic [4:0]  channel_out,
    output logic        eoc_out,
    output logic        eos_out,
    output logic        busy_out,
    output logic [4:0]  smp_ch,
    input  logic [11:0] smp_data
);
    localparam logic [15:0] CONV_LAST = 16'(CONV_CYCLES - 1);
    localparam logic [15:0] LAT_LAST  = 16'(DRP_LAT - 1);

    function automatic logic [4:0] seq_ch(input logic [2:0] i);
        return i == 3'd0 ? 5'd0 : i == 3'd1 ? 5'd1 : i == 3'd2 ? 5'd18 :
               i == 3'd3 ? 5'd19 : i == 3'd4 ? 5'd26 : 5'd27;
    endfunction

    logic [2:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busy_q, busy_d, eoc_q, eoc_d, eos_q, eos_d;
    logic [4:0]  chout_q, chout_d;
    logic [11:0] st_q [6];
    logic [11:0] st_d [6];
    logic [15:0] cfg_q [4];
    logic [15:0] cfg_d [4];
    logic        pend_q, pend_d, drdy_q, drdy_d;
    logic [15:0] lcnt_q, lcnt_d, rdata_q, rdata_d;
    logic [15:0] rd_val;
    logic        term, acc, cfg_hit;

    assign term    = busy_q && cnt_q == CONV_LAST;
    assign acc     = den_in && !pend_q;
    assign cfg_hit = daddr_in[6:2] == 5'b10000 && daddr_in[1:0] != 2'b11;

    // Register-map read mux; status slots exist only for sequenced channels, the rest read 0
    always_comb begin
        rd_val = 16'h0;
        for (int i = 0; i < 6; i++)
            if (daddr_in == {2'b00, seq_ch(3'(i))}) rd_val = {st_q[i], 4'h0};
        if (cfg_hit) rd_val = cfg_q[daddr_in[1:0]];
    end

    // Sequencer: count, capture on terminal count, then advance and restart unless halted
    always_comb begin
        busy_d  = busy_q ? !term : !cfg_q[1][0];
        cnt_d   = busy_q && !term ? cnt_q + 16'd1 : 16'd0;
        eoc_d   = term;
        eos_d   = term && idx_q == 3'd5;
        idx_d   = eoc_q ? (idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1) : idx_q;
        chout_d = term ? seq_ch(idx_q) : chout_q;
        st_d    = st_q;
        if (term) st_d[idx_q] = smp_data;
    end

    // DRP: one outstanding transaction, completion strobe DRP_LAT cycles after acceptance
    always_comb begin
        drdy_d  = (acc && DRP_LAT == 1) || (pend_q && lcnt_q == LAT_LAST);
        pend_d  = pend_q ? lcnt_q != LAT_LAST : acc && DRP_LAT > 1;
        lcnt_d  = pend_q ? lcnt_q + 16'd1 : 16'd1;
        rdata_d = acc ? (dwe_in ? 16'h0 : rd_val) : rdata_q;
        cfg_d   = cfg_q;
        if (acc && dwe_in && cfg_hit) cfg_d[daddr_in[1:0]] = di_in;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            eoc_q   <= 1'b0;
            eos_q   <= 1'b0;
            chout_q <= '0;
            st_q    <= '{default: '0};
            cfg_q   <= '{default: '0};
            pend_q  <= 1'b0;
            drdy_q  <= 1'b0;
            lcnt_q  <= '0;
            rdata_q <= '0;
        end else begin
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            eoc_q   <= eoc_d;
            eos_q   <= eos_d;
            chout_q <= chout_d;
            st_q    <= st_d;
            cfg_q   <= cfg_d;
            pend_q  <= pend_d;
            drdy_q  <= drdy_d;
            lcnt_q  <= lcnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign drdy_out    = drdy_q;
    assign do_out      = drdy_q ? rdata_q : 16'h0;
    assign channel_out = chout_q;
    assign eoc_out     = eoc_q;
    assign eos_out     = eos_q;
    assign busy_out    = busy_q;
    assign smp_ch      = seq_ch(idx_q);
endmodule

// File: doc/xadc_drp_responder.md
# xadc_drp_responder

Synthesizable stand-in for the XADC hard macro: the responder end of the DRP interface plus a free-running channel sequencer. It presents the same DRP and conversion-status ports that the ADC MMIO core drives and consumes, with digital sample inputs in place of the analog front end. It is used on targets without an XADC and as the DRP responder in SoC-level simulation.

## Interface

Parameters:
- CONV_CYCLES, 26, clk cycles per conversion; legal range ≥ 2.
- DRP_LAT, 2, cycles from the den_in cycle to the drdy_out cycle; legal range ≥ 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- den_in  in  1  DRP enable, single-cycle request strobe.
- dwe_in  in  1  DRP write enable; sampled with den_in.
- daddr_in  in  7  DRP register address.
- di_in  in  16  DRP write data.
- drdy_out  out  1  one-cycle transaction-complete strobe.
- do_out  out  16  DRP read data; valid only while drdy_out = 1.
- channel_out  out  5  channel of the most recently completed conversion.
- eoc_out  out  1  end-of-conversion pulse.
- eos_out  out  1  end-of-sequence pulse.
- busy_out  out  1  high while a conversion is counting.
- smp_ch  out  5  channel currently being converted.
- smp_data  in  12  sample value for smp_ch, supplied by the bench or top level.

## Operation

- Sequence order: 0 (temp), 1 (vccint), 18 (vaux2), 19 (vaux3), 26 (vaux10), 27 (vaux11), then wrap back to 0.
- Conversion:
  - A counter runs 0..CONV_CYCLES-1 with busy_out = 1.
  - On the terminal count, status[ch] ← {smp_data, 4'h0}. This uses 12-bit MSB-justified format.
  - On the same edge, eoc_out = 1 for one cycle and channel_out = ch.
  - eos_out = 1 on that same cycle only when ch = 27.
  - busy_out = 0 during the eoc cycle.
  - The next conversion starts on the following cycle, and smp_ch advances to the next channel at that point.
- Register map, 128 × 16:
  - 0x00–0x1F are status registers. DRP writes to them are ignored.
  - 0x40–0x42 are config registers, read/write, reset value 0.
  - All other addresses read 0 and ignore writes.
- Halt control: cfg1 (0x41) bit 0 is seq_halt.
  - When seq_halt = 1, the in-flight conversion completes normally.
  - The sequencer then idles: busy_out = 0, no eoc_out pulses, and smp_ch holds the next channel.
  - Clearing seq_halt resumes conversion on the next cycle at that held channel.
- DRP transaction:
  - A den_in cycle latches daddr, di and dwe.
  - For a read, the register value is snapshotted in that same cycle.
  - For a write, the target register updates on the edge ending the den_in cycle, and do_out = 0 at completion.
  - drdy_out pulses exactly DRP_LAT cycles after the den_in cycle.
- Only one transaction is outstanding at a time. A den_in that arrives while a transaction is pending is dropped: no effect, no extra drdy_out, and the in-flight transaction is unaffected.
- do_out is 0 whenever drdy_out = 0.

## Timing

- Reset values:
  - drdy_out = 0, do_out = 0.
  - eoc_out = 0, eos_out = 0, busy_out = 0.
  - channel_out = 0, smp_ch = 0.
  - All registers 0, with no transaction pending.
- First conversion:
  - busy_out rises on the first clk edge after reset deasserts.
  - The first eoc_out occurs CONV_CYCLES cycles after that rise.
  - Conversion period is CONV_CYCLES + 1 cycles.
- Status update vs. read:
  - The status update and eoc_out occur on the same edge, so a read with den_in asserted in the eoc cycle returns the new value.
  - This makes the loopback den_in = eoc_out, daddr_in = {2'b00, channel_out} return the fresh conversion.
  - A read of status[ch] issued on the cycle before that update returns the old value.
- Simultaneous events:
  - A DRP write to 0x41 setting seq_halt in the last conversion cycle does not stop that conversion; halting takes effect afterwards.
  - A write to a status address at the same moment as an update is ignored; the conversion value wins.
- Asynchronous reset mid-operation:
  - An in-flight transaction is aborted and no drdy_out is issued.
  - Any partial conversion is discarded.
  - The sequence restarts at channel 0.

## Test plan

- Sequence: smp_data = 0xABC, CONV_CYCLES = 26 → first eoc_out 26 cycles after busy_out rises, with channel_out = 0. Subsequent eoc_out pulses occur every 27 cycles with channels 0, 1, 18, 19, 26, 27, 0. eos_out is asserted only on the channel-27 eoc.
- Loopback: den_in = eoc_out, daddr_in = {2'b00, channel_out}, with smp_data = channel×16 → drdy_out exactly DRP_LAT = 2 cycles after each eoc_out. do_out equals {smp_data, 4'h0} for that channel (e.g. channel 19 returns 0x1300).
- Config/status access:
  - Write 0x1234 to 0x40, then read 0x40 → 0x1234.
  - Write 0xFFFF to 0x13, then read 0x13 → last conversion value, unchanged by the write.
  - Read 0x7F → 0x0000.
- Overlap: read of 0x40 issued, then den_in with a write of 0x5555 to 0x42 in the next cycle → only one drdy_out is produced, and 0x42 reads back 0.
- Halt: write 0x0001 to 0x41 mid-conversion of channel 18 → channel 18's eoc_out still occurs, then no eoc_out for 100 cycles with busy_out = 0. Writing 0x0000 to 0x41 resumes conversions, and the next eoc_out reports channel 19.
- Reset mid-transaction: assert reset 1 cycle after a den_in read → no drdy_out is ever produced. All outputs read 0, and the first post-reset eoc_out reports channel 0.
